// File: rtl/mul_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit_pkg
// Description : Shared constants for the multiply/divide unit and the decoder
//               that drives it: opcode encodings, FSM state encodings and
//               small opcode classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_div_unit_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;

  // Opcode presented by the decoder alongside the start strobe
  typedef enum logic [OP_W-1:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } mdu_op_e;

  // Sequencer states; anything other than IDLE means an operation is in flight
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

  // True for the two multiply opcodes
  function automatic logic is_mul_op(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  // True for the two divide opcodes
  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage : mul_div_unit_pkg
`default_nettype wire

// File: rtl/mul_div_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit_if
// Description : Decoder-to-MDU bundle. The master side (decoder / hazard
//               logic) drives opcode, strobe and operands; the slave side
//               (mul_div_unit) returns busy, HI/LO and the mfhi/mflo data.
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_div_unit_if;
  import mul_div_unit_pkg::*;

  logic [OP_W-1:0]   mul_op;
  logic              start;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              busy;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output mul_op, start, a, b,
    input  busy, hi, lo, rd_data
  );

  modport slave (
    input  mul_op, start, a, b,
    output busy, hi, lo, rd_data
  );

endinterface : mul_div_unit_if
`default_nettype wire

// File: rtl/mul_div_unit_arith.sv
`default_nettype none
// ============================================================================
// Module      : mdu_arith
// Description : Purely combinational datapath for the MDU. Produces the
//               64-bit {hi,lo} result for mult/multu (product) and div/divu
//               ({remainder,quotient}) plus a divide-by-zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_arith
  import mul_div_unit_pkg::*;
(
  input  logic [OP_W-1:0]     op,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic [2*DATA_W-1:0] result,
  output logic                div_by_zero
);

  logic [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0] prod_u;
  logic                a_neg;
  logic                b_neg;
  logic [DATA_W-1:0]   a_mag;
  logic [DATA_W-1:0]   b_mag;
  logic [DATA_W-1:0]   b_mag_safe;
  logic [DATA_W-1:0]   b_safe;
  logic [DATA_W-1:0]   q_mag;
  logic [DATA_W-1:0]   r_mag;
  logic [DATA_W-1:0]   q_s;
  logic [DATA_W-1:0]   r_s;
  logic [DATA_W-1:0]   q_u;
  logic [DATA_W-1:0]   r_u;

  // Full-width products: sign-extend for mult, zero-extend for multu
  assign prod_s = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
  assign prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

  // Signed divide is done on magnitudes so that 0x80000000 / -1 simply wraps
  // instead of relying on tool-specific overflow behaviour. A zero divisor is
  // replaced with 1 to keep the dividers well-defined; the result is discarded.
  always_comb begin
    a_neg      = a[DATA_W-1];
    b_neg      = b[DATA_W-1];
    a_mag      = a_neg ? (~a + 1'b1) : a;
    b_mag      = b_neg ? (~b + 1'b1) : b;
    b_mag_safe = (b_mag == '0) ? {{(DATA_W-1){1'b0}}, 1'b1} : b_mag;
    b_safe     = (b == '0) ? {{(DATA_W-1){1'b0}}, 1'b1} : b;
    q_mag      = a_mag / b_mag_safe;
    r_mag      = a_mag % b_mag_safe;
    q_s        = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
    r_s        = a_neg ? (~r_mag + 1'b1) : r_mag;
    q_u        = a / b_safe;
    r_u        = a % b_safe;
  end

  // Select the result for the requested operation
  always_comb begin
    result      = '0;
    div_by_zero = 1'b0;
    case (op)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV: begin
        result      = {r_s, q_s};
        div_by_zero = (b == '0);
      end
      OP_DIVU: begin
        result      = {r_u, q_u};
        div_by_zero = (b == '0);
      end
      default: result = '0;
    endcase
  end

endmodule : mdu_arith
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative-latency multiply/divide unit with HI/LO registers.
//               The result is computed on the launch edge and held in pending
//               registers; a down-counter models the latency and the pending
//               value is committed to HI/LO on the last busy cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic           clk,
  input  logic           reset_n,
  mul_div_unit_if.slave  bus
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  mdu_state_e          state;
  mdu_state_e          state_nxt;
  logic [CNT_W-1:0]    counter;
  logic [CNT_W-1:0]    counter_nxt;
  logic [DATA_W-1:0]   pend_hi;
  logic [DATA_W-1:0]   pend_hi_nxt;
  logic [DATA_W-1:0]   pend_lo;
  logic [DATA_W-1:0]   pend_lo_nxt;
  logic                pend_valid;
  logic                pend_valid_nxt;
  logic [DATA_W-1:0]   hi_reg;
  logic [DATA_W-1:0]   hi_nxt;
  logic [DATA_W-1:0]   lo_reg;
  logic [DATA_W-1:0]   lo_nxt;
  logic [2*DATA_W-1:0] arith_result;
  logic                arith_dbz;

  mdu_arith u_arith (
    .op          (bus.mul_op),
    .a           (bus.a),
    .b           (bus.b),
    .result      (arith_result),
    .div_by_zero (arith_dbz)
  );

  // State, counter, pending result and architectural HI/LO registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      counter    <= '0;
      pend_hi    <= '0;
      pend_lo    <= '0;
      pend_valid <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      state      <= state_nxt;
      counter    <= counter_nxt;
      pend_hi    <= pend_hi_nxt;
      pend_lo    <= pend_lo_nxt;
      pend_valid <= pend_valid_nxt;
      hi_reg     <= hi_nxt;
      lo_reg     <= lo_nxt;
    end
  end

  // Next-state logic: launch from IDLE, count down, commit on the last cycle
  always_comb begin
    state_nxt      = state;
    counter_nxt    = counter;
    pend_hi_nxt    = pend_hi;
    pend_lo_nxt    = pend_lo;
    pend_valid_nxt = pend_valid;
    hi_nxt         = hi_reg;
    lo_nxt         = lo_reg;
    case (state)
      ST_IDLE: begin
        if (bus.start && is_mul_op(bus.mul_op)) begin
          pend_hi_nxt    = arith_result[2*DATA_W-1:DATA_W];
          pend_lo_nxt    = arith_result[DATA_W-1:0];
          pend_valid_nxt = 1'b1;
          counter_nxt    = MUL_CNT;
          state_nxt      = ST_MUL;
        end else if (bus.start && is_div_op(bus.mul_op)) begin
          // Divide by zero still spends the full latency but never commits
          pend_hi_nxt    = arith_result[2*DATA_W-1:DATA_W];
          pend_lo_nxt    = arith_result[DATA_W-1:0];
          pend_valid_nxt = ~arith_dbz;
          counter_nxt    = DIV_CNT;
          state_nxt      = ST_DIV;
        end else if (bus.mul_op == OP_MTHI) begin
          hi_nxt = bus.a;
        end else if (bus.mul_op == OP_MTLO) begin
          lo_nxt = bus.a;
        end
      end
      ST_MUL, ST_DIV: begin
        // New starts and mthi/mtlo are ignored here; the hazard unit stalls them
        if (counter != '0) begin
          counter_nxt = counter - CNT_ONE;
        end else begin
          if (pend_valid) begin
            hi_nxt = pend_hi;
            lo_nxt = pend_lo;
          end
          pend_valid_nxt = 1'b0;
          state_nxt      = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs: busy from state, HI/LO straight from the registers
  assign bus.busy = (state != ST_IDLE);
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;

  // mfhi/mflo read port; returns the current register even while busy
  always_comb begin
    bus.rd_data = '0;
    if (bus.mul_op == OP_MFHI) begin
      bus.rd_data = hi_reg;
    end else if (bus.mul_op == OP_MFLO) begin
      bus.rd_data = lo_reg;
    end
  end

endmodule : mul_div_unit
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Self-checking bench for mul_div_unit: directed vector table,
//               protocol/reset corner sequences and a randomized run checked
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          viol = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  vec_t        vecs[9];
  logic [31:0] specials[6];

  mul_div_unit_if bus ();

  mul_div_unit #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Protocol monitor: a start accepted while busy is a hazard-unit violation
  always @(posedge clk) begin
    if (reset_n && bus.busy && bus.start) begin
      viol++;
      $display("note: start strobe seen while busy at %0t", $time);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic straight from the ISA rules
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] h, inout logic [31:0] l, output int cyc);
    longint      x;
    longint      y;
    longint      q;
    longint      r;
    logic [63:0] p;
    cyc = 0;
    case (op)
      4'd1: begin
        p = longint'($signed(a)) * longint'($signed(b));
        h = p[63:32]; l = p[31:0]; cyc = MUL_LAT;
      end
      4'd2: begin
        p = {32'b0, a} * {32'b0, b};
        h = p[63:32]; l = p[31:0]; cyc = MUL_LAT;
      end
      4'd3: begin
        cyc = DIV_LAT;
        if (b != 0) begin
          x = longint'($signed(a)); y = longint'($signed(b));
          q = x / y; r = x % y;
          l = q[31:0]; h = r[31:0];
        end
      end
      4'd4: begin
        cyc = DIV_LAT;
        if (b != 0) begin
          l = a / b; h = a % b;
        end
      end
      4'd7: h = a;
      4'd8: l = a;
      default: cyc = 0;
    endcase
  endfunction

  // Drive one operation at a falling edge, then count busy cycles (bounded)
  task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv, output int cyc);
    @(negedge clk);
    bus.mul_op = op;
    bus.start  = (op >= 4'd1 && op <= 4'd4);
    bus.a      = av;
    bus.b      = bv;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.mul_op = 4'd0;
    cyc = 0;
    while (bus.busy && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Combinational read port against the model's HI/LO
  task automatic check_read(input string tag);
    @(negedge clk);
    bus.mul_op = 4'd5; #1;
    check({tag, "_mfhi"}, bus.rd_data, m_hi);
    bus.mul_op = 4'd6; #1;
    check({tag, "_mflo"}, bus.rd_data, m_lo);
    bus.mul_op = 4'd0; #1;
    check({tag, "_rd_none"}, bus.rd_data, 32'h0);
  endtask

  initial begin
    int cyc;
    int mcyc;
    logic [3:0]  op;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [3:0]  ops[6];

    vecs[0] = '{4'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MUL_LAT};
    vecs[1] = '{4'd2, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, MUL_LAT};
    vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT};
    vecs[3] = '{4'd4, 32'd7,        32'd2,        32'h00000001, 32'h00000003, DIV_LAT};
    vecs[4] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_LAT};
    vecs[5] = '{4'd7, 32'h11111111, 32'd0,        32'h11111111, 32'h80000000, 0};
    vecs[6] = '{4'd8, 32'h22222222, 32'd0,        32'h11111111, 32'h22222222, 0};
    vecs[7] = '{4'd3, 32'd5,        32'd0,        32'h11111111, 32'h22222222, DIV_LAT};
    vecs[8] = '{4'd4, 32'd5,        32'd0,        32'h11111111, 32'h22222222, DIV_LAT};

    specials = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFE};
    ops      = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8};

    bus.mul_op = 4'd0;
    bus.start  = 1'b0;
    bus.a      = '0;
    bus.b      = '0;

    // Reset state
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, bus.busy}, 32'h0);
    check("reset_hi", bus.hi, 32'h0);
    check("reset_lo", bus.lo, 32'h0);
    check("reset_rd", bus.rd_data, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
      check($sformatf("vec%0d_cycles", i), cyc, vecs[i].exp_cyc);
      check($sformatf("vec%0d_hi", i), bus.hi, vecs[i].exp_hi);
      check($sformatf("vec%0d_lo", i), bus.lo, vecs[i].exp_lo);
      m_hi = vecs[i].exp_hi;
      m_lo = vecs[i].exp_lo;
      check_read($sformatf("vec%0d", i));
    end

    // Second start and an mthi arriving during a busy mult are both dropped
    @(negedge clk);
    bus.mul_op = 4'd1; bus.start = 1'b1; bus.a = 32'd3; bus.b = 32'd4;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.mul_op = 4'd0;
    cyc = 0;
    @(negedge clk);
    bus.mul_op = 4'd1; bus.start = 1'b1; bus.a = 32'd2; bus.b = 32'd2;
    @(posedge clk); #1;
    cyc++;
    @(negedge clk);
    bus.mul_op = 4'd7; bus.start = 1'b0; bus.a = 32'h0000DEAD;
    @(posedge clk); #1;
    cyc++;
    bus.mul_op = 4'd0;
    while (bus.busy && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("midop_cycles", cyc, MUL_LAT);
    check("midop_hi", bus.hi, 32'h0);
    check("midop_lo", bus.lo, 32'd12);
    check("midop_violation_seen", {31'b0, (viol > 0)}, 32'h1);
    m_hi = 32'h0;
    m_lo = 32'd12;

    // Asynchronous reset in the middle of a divide: clears at once, no late commit
    issue(4'd7, 32'hAAAA5555, 32'd0, cyc);
    issue(4'd8, 32'h5555AAAA, 32'd0, cyc);
    check("prerst_hi", bus.hi, 32'hAAAA5555);
    @(negedge clk);
    bus.mul_op = 4'd3; bus.start = 1'b1; bus.a = 32'd100; bus.b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.mul_op = 4'd0;
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'b0, bus.busy}, 32'h0);
    check("rst_mid_hi", bus.hi, 32'h0);
    check("rst_mid_lo", bus.lo, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    m_hi = '0;
    m_lo = '0;
    repeat (15) @(posedge clk);
    #1;
    check("rst_after_busy", {31'b0, bus.busy}, 32'h0);
    check("rst_after_hi", bus.hi, 32'h0);
    check("rst_after_lo", bus.lo, 32'h0);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 5)];
      ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000000F;
      model(op, ra, rb, m_hi, m_lo, mcyc);
      issue(op, ra, rb, cyc);
      check($sformatf("rnd%0d_cycles", i), cyc, mcyc);
      check($sformatf("rnd%0d_hi", i), bus.hi, m_hi);
      check($sformatf("rnd%0d_lo", i), bus.lo, m_lo);
      if (i % 8 == 0) check_read($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mul_div_unit
`default_nettype wire

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative-latency multiply/divide unit with HI/LO registers.
- Sits in EX, directly downstream of the instruction decoder.
- Consumes the decoder's 4-bit multiply/divide opcode and start strobe, plus the two forwarded register operands.
- Exposes busy to the hazard unit so it can stall, and returns HI or LO for mfhi/mflo.

Parameters:
- MUL_LAT, 5, busy cycles for mult/multu (>=1)
- DIV_LAT, 10, busy cycles for div/divu (>=1)

Ports:
- clk  input  1  single system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- mul_op  input  4  opcode: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo
- start  input  1  launch strobe; asserted by the decoder only for opcodes 1-4
- a  input  32  rs operand
- b  input  32  rt operand
- busy  output  1  operation in flight
- hi  output  32  HI register
- lo  output  32  LO register
- rd_data  output  32  combinational: hi if mul_op=5, lo if mul_op=6, else 0

Behaviour:
- Reset: async on reset_n low. hi=0, lo=0, busy=0, state=IDLE, counter=0, pending regs=0. Reset mid-operation aborts it; no commit occurs.
- FSM states:
  - IDLE: busy=0.
  - MUL: busy=1.
  - DIV: busy=1.
- IDLE + start + mul_op in {1,2}:
  - Compute the 64-bit product into pend_hi/pend_lo on this edge.
  - Load counter=MUL_LAT-1 and go to MUL.
  - mult treats a and b as signed; multu as unsigned.
- IDLE + start + mul_op in {3,4}:
  - Compute the result into pend_hi/pend_lo on this edge: pend_lo=quotient, pend_hi=remainder.
  - Load counter=DIV_LAT-1 and go to DIV.
- Signed div:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
- Divide by zero (b=0, div or divu): the full latency is still spent, but HI/LO are not updated (the pending-valid flag is cleared).
- MUL/DIV, counter!=0: decrement the counter.
- MUL/DIV, counter==0: commit pend_hi/pend_lo to hi/lo (if the pending-valid flag is set) and return to IDLE.
- Timing: start sampled at edge E0 gives busy=1 for exactly MUL_LAT (DIV_LAT) cycles after E0; new hi/lo are visible in the same cycle busy falls.
- start while busy: ignored. The hazard unit guarantees this never happens; a bench assertion flags it.
- mthi/mtlo (7/8), in IDLE with busy=0: write a into hi/lo at the edge.
- mthi/mtlo while busy: ignored (the hazard unit stalls these).
- mthi/mtlo, commit priority: no overlap is possible, since a commit occurs only in MUL/DIV.
- start with mul_op outside 1-4: ignored, no state change.
- rd_data is purely combinational from the current hi/lo. mfhi/mflo during busy returns the old value; the stall is the hazard unit's job.
- No other outputs change in IDLE without mthi/mtlo.

Decomposition:
- Shared package (constants header): the mul_op encodings 0-8 and the state encodings IDLE/MUL/DIV.
- The decoder and this block both include it.
- Natural sub-module: mdu_arith, combinational. It takes op, a, b and returns a 64-bit {hi,lo} result plus div_by_zero. It isolates signed/unsigned multiply and divide from the FSM/counter/register logic.

Test Plan:
- Reset:
  - Stimulus: assert reset_n=0 asynchronously mid-cycle during a DIV.
  - Required: busy, hi and lo go to 0 immediately; after release, no stale commit occurs.
- Signed mult:
  - Stimulus: mult a=0xFFFFFFFE (-2), b=3.
  - Required: busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands gives hi=0x00000002, lo=0xFFFFFFFA.
- Signed div:
  - div a=-7 (0xFFFFFFF9), b=2: busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu a=7, b=2: lo=3, hi=1.
  - div 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero:
  - Stimulus: mthi 0x11111111, mtlo 0x22222222, then div a=5, b=0.
  - Required: busy for 10 cycles, then hi=0x11111111, lo=0x22222222 unchanged.
- Mid-operation protocol:
  - Stimulus: start a second mult (a=2, b=2) and an mthi 0xDEAD during a busy mult (a=3, b=4).
  - Required: both are ignored; final lo=12, hi=0, assertion fires.
- Read path:
  - mfhi/mflo in IDLE returns hi/lo combinationally in the same cycle.
  - mul_op=0 gives rd_data=0.
